// File: rtl/approx_mul_pkg.sv
// Shared types and constants for the iterative approximate multiplier.
package approx_mul_pkg;

    // Operands are processed as radix-4 digits.
    localparam int DIGIT_W = 2;
    // A digit-by-digit partial product fits in four bits.
    localparam int CELL_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True when both digits are 3, the only pair where the approximate cell differs.
    function automatic logic both_three(input logic [DIGIT_W-1:0] x, input logic [DIGIT_W-1:0] y);
        return (x == 2'd3) && (y == 2'd3);
    endfunction

endpackage

// File: rtl/approx_mul_iter_if.sv
// Request/response bundle for the iterative approximate multiplier.
interface approx_mul_iter_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 mode_exact;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out;
    logic                 approx_hit;

    // Requester side: issues operands and consumes the product.
    modport master (
        output in_valid, a, b, mode_exact, out_ready,
        input  in_ready, out_valid, out, approx_hit
    );

    // Multiplier side.
    modport slave (
        input  in_valid, a, b, mode_exact, out_ready,
        output in_ready, out_valid, out, approx_hit
    );
endinterface

// File: rtl/approx_mul2_cell.sv
// 2x2-bit digit multiplier with an optional approximation of 3x3 as 7.
module approx_mul2_cell
    import approx_mul_pkg::*;
(
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    input  logic               approx,
    output logic [CELL_W-1:0]  p
);

    logic [CELL_W-1:0] x_ext_s;
    logic [CELL_W-1:0] pp0_s;
    logic [CELL_W-1:0] pp1_s;
    logic [CELL_W-1:0] exact_s;

    // Shift-and-add digit product, replaced by 7 when approximating 3x3.
    always_comb begin
        x_ext_s = CELL_W'(x);
        pp0_s   = y[0] ? x_ext_s : 4'd0;
        pp1_s   = y[1] ? (x_ext_s << 1) : 4'd0;
        exact_s = pp0_s + pp1_s;
        if (approx && both_three(x, y)) begin
            p = 4'd7;
        end else begin
            p = exact_s;
        end
    end

endmodule

// File: rtl/approx_mul_iter.sv
// Iterative radix-4 multiplier: one digit pair per clock through a single
// shared 2x2 cell, with low-significance pairs optionally approximated.
module approx_mul_iter
    import approx_mul_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int APPROX_K = 2
) (
    input  logic             clk,
    input  logic             reset,
    approx_mul_iter_if.slave bus
);

    localparam int D      = WIDTH / DIGIT_W;
    localparam int IDX_W  = (D > 1) ? $clog2(D) : 1;
    localparam int SUM_W  = IDX_W + 1;
    localparam int PROD_W = 2 * WIDTH;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(D - 1);
    localparam logic [SUM_W-1:0] K_THR    = SUM_W'(APPROX_K);

    state_t              state_r;
    state_t              state_n;
    logic                in_ready_r;
    logic                out_valid_r;

    logic [WIDTH-1:0]    a_r;
    logic [WIDTH-1:0]    b_r;
    logic                mode_r;
    logic [PROD_W-1:0]   acc_r;
    logic                hit_r;
    logic [IDX_W-1:0]    i_r;
    logic [IDX_W-1:0]    j_r;

    logic [SUM_W-1:0]    sum_s;
    logic [SUM_W:0]      shamt_s;
    logic [DIGIT_W-1:0]  x_s;
    logic [DIGIT_W-1:0]  y_s;
    logic                approx_s;
    logic [CELL_W-1:0]   p_s;
    logic [PROD_W-1:0]   term_s;
    logic                pair_hit_s;
    logic                last_s;

    // Select the current digit pair and form its weighted contribution.
    always_comb begin
        sum_s      = {1'b0, i_r} + {1'b0, j_r};
        shamt_s    = {sum_s, 1'b0};
        x_s        = DIGIT_W'(a_r >> {i_r, 1'b0});
        y_s        = DIGIT_W'(b_r >> {j_r, 1'b0});
        approx_s   = !mode_r && (sum_s < K_THR);
        term_s     = PROD_W'(p_s) << shamt_s;
        pair_hit_s = approx_s && both_three(x_s, y_s);
        last_s     = (i_r == LAST_IDX) && (j_r == LAST_IDX);
    end

    approx_mul2_cell u_cell (
        .x      (x_s),
        .y      (y_s),
        .approx (approx_s),
        .p      (p_s)
    );

    // Next-state logic for the accept / iterate / hold-result sequence.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_n = ST_RUN;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_n = ST_DONE;
                end else begin
                    state_n = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_DONE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State register plus registered handshake flags decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_n;
            in_ready_r  <= (state_n == ST_IDLE);
            out_valid_r <= (state_n == ST_DONE);
        end
    end

    // Operand capture, accumulation and pair sequencing (j outer, i inner).
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r    <= '0;
            b_r    <= '0;
            mode_r <= 1'b0;
            acc_r  <= '0;
            hit_r  <= 1'b0;
            i_r    <= '0;
            j_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_r    <= bus.a;
                        b_r    <= bus.b;
                        mode_r <= bus.mode_exact;
                        acc_r  <= '0;
                        hit_r  <= 1'b0;
                        i_r    <= '0;
                        j_r    <= '0;
                    end else begin
                        acc_r  <= acc_r;
                    end
                end
                ST_RUN: begin
                    acc_r <= acc_r + term_s;
                    hit_r <= hit_r | pair_hit_s;
                    if (i_r == LAST_IDX) begin
                        i_r <= '0;
                        if (j_r == LAST_IDX) begin
                            j_r <= '0;
                        end else begin
                            j_r <= j_r + IDX_W'(1);
                        end
                    end else begin
                        i_r <= i_r + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    acc_r <= acc_r;
                end
                default: begin
                    acc_r <= '0;
                    hit_r <= 1'b0;
                    i_r   <= '0;
                    j_r   <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out        = acc_r;
    assign bus.approx_hit = hit_r;

endmodule

// File: tb/tb_approx_mul_iter.sv
// Self-checking bench: three configurations (W4/K3, W4/K1, W8/K2) with a
// scoreboard queue of expected products filled at issue time.
module tb_approx_mul_iter;

    typedef struct packed {
        logic [31:0] prod;
        logic        hit;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    exp_t sb_q[$];

    approx_mul_iter_if #(.WIDTH(4)) if0 ();
    approx_mul_iter_if #(.WIDTH(4)) if1 ();
    approx_mul_iter_if #(.WIDTH(8)) if2 ();

    approx_mul_iter #(.WIDTH(4), .APPROX_K(3)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
    approx_mul_iter #(.WIDTH(4), .APPROX_K(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
    approx_mul_iter #(.WIDTH(8), .APPROX_K(2)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cfg_w(input int sel);
        return (sel == 2) ? 8 : 4;
    endfunction

    function automatic int cfg_k(input int sel);
        return (sel == 0) ? 3 : ((sel == 1) ? 1 : 2);
    endfunction

    // Exact product minus 2*4^(i+j) for every approximated pair of two 3-digits.
    function automatic logic [31:0] model_prod(input int w, input int k, input int av,
                                               input int bv, input bit m, output bit hit);
        int d;
        logic [31:0] r;
        d   = w / 2;
        r   = 32'(av * bv);
        hit = 1'b0;
        for (int j = 0; j < d; j++) begin
            for (int i = 0; i < d; i++) begin
                if (!m && (i + j) < k && ((av >> (2 * i)) & 3) == 3 && ((bv >> (2 * j)) & 3) == 3) begin
                    r   = r - (32'd2 << (2 * (i + j)));
                    hit = 1'b1;
                end
            end
        end
        return r;
    endfunction

    function automatic logic get_ov(input int sel);
        case (sel)
            0:       return if0.out_valid;
            1:       return if1.out_valid;
            default: return if2.out_valid;
        endcase
    endfunction

    function automatic logic get_ir(input int sel);
        case (sel)
            0:       return if0.in_ready;
            1:       return if1.in_ready;
            default: return if2.in_ready;
        endcase
    endfunction

    function automatic logic get_hit(input int sel);
        case (sel)
            0:       return if0.approx_hit;
            1:       return if1.approx_hit;
            default: return if2.approx_hit;
        endcase
    endfunction

    function automatic logic [31:0] get_out(input int sel);
        case (sel)
            0:       return 32'(if0.out);
            1:       return 32'(if1.out);
            default: return 32'(if2.out);
        endcase
    endfunction

    task automatic drive_in(input int sel, input bit v, input int av, input int bv, input bit m);
        case (sel)
            0: begin if0.in_valid = v; if0.a = 4'(av); if0.b = 4'(bv); if0.mode_exact = m; end
            1: begin if1.in_valid = v; if1.a = 4'(av); if1.b = 4'(bv); if1.mode_exact = m; end
            default: begin if2.in_valid = v; if2.a = 8'(av); if2.b = 8'(bv); if2.mode_exact = m; end
        endcase
    endtask

    // Issue one operation from IDLE; optionally record its expected result.
    task automatic start_op(input int sel, input int av, input int bv, input bit m, input bit push);
        exp_t e;
        bit   h;
        @(negedge clk);
        checks++;
        if (get_ir(sel) !== 1'b1) begin
            failures++;
            $display("FAIL start_in_ready sel=%0d: got %0b expected 1", sel, get_ir(sel));
        end
        drive_in(sel, 1'b1, av, bv, m);
        e.prod = model_prod(cfg_w(sel), cfg_k(sel), av, bv, m, h);
        e.hit  = h;
        if (push) sb_q.push_back(e);
        @(posedge clk);
        #1;
        drive_in(sel, 1'b0, av, bv, m);
    endtask

    task automatic wait_out(input int sel, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (get_ov(sel) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Compare a presented result with the scoreboard head, then complete the handshake.
    task automatic check_result(input int sel, input string name, input int cyc, input bit ok,
                                input bit do_hs, output logic [31:0] o, output logic h);
        exp_t e;
        int   lat;
        lat = (cfg_w(sel) / 2) * (cfg_w(sel) / 2);
        o   = get_out(sel);
        h   = get_hit(sel);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_timeout: out_valid not seen within 100 cycles", name);
        end
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL %s_sb_empty: got empty queue expected an entry", name);
            return;
        end
        e = sb_q.pop_front();
        if (!ok) return;
        checks++;
        if (o !== e.prod) begin
            failures++;
            $display("FAIL %s_out: got %0d expected %0d", name, o, e.prod);
        end
        checks++;
        if (h !== e.hit) begin
            failures++;
            $display("FAIL %s_hit: got %0b expected %0b", name, h, e.hit);
        end
        checks++;
        if (cyc != lat) begin
            failures++;
            $display("FAIL %s_latency: got %0d expected %0d", name, cyc, lat);
        end
        if (do_hs) begin
            @(posedge clk);
            #1;
            checks++;
            if (get_ov(sel) !== 1'b0 || get_ir(sel) !== 1'b1) begin
                failures++;
                $display("FAIL %s_release: got ov=%0b ir=%0b expected ov=0 ir=1", name, get_ov(sel), get_ir(sel));
            end
        end
    endtask

    task automatic collect(input int sel, input string name, output logic [31:0] o, output logic h);
        int cyc;
        bit ok;
        wait_out(sel, cyc, ok);
        check_result(sel, name, cyc, ok, 1'b1, o, h);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (get_ir(s) !== 1'b1) begin failures++; $display("FAIL reset_in_ready sel=%0d: got %0b expected 1", s, get_ir(s)); end
            checks++;
            if (get_ov(s) !== 1'b0) begin failures++; $display("FAIL reset_out_valid sel=%0d: got %0b expected 0", s, get_ov(s)); end
            checks++;
            if (get_out(s) !== 32'd0) begin failures++; $display("FAIL reset_out sel=%0d: got %0d expected 0", s, get_out(s)); end
            checks++;
            if (get_hit(s) !== 1'b0) begin failures++; $display("FAIL reset_hit sel=%0d: got %0b expected 0", s, get_hit(s)); end
        end
    endtask

    task automatic test_small_vectors();
        logic [31:0] o;
        logic        h;
        start_op(0, 15, 15, 1'b0, 1'b1);
        collect(0, "k3_approx", o, h);
        checks++;
        if (o !== 32'd175 || h !== 1'b1) begin failures++; $display("FAIL k3_approx_const: got %0d/%0b expected 175/1", o, h); end
        start_op(0, 15, 15, 1'b1, 1'b1);
        collect(0, "k3_exact", o, h);
        checks++;
        if (o !== 32'd225 || h !== 1'b0) begin failures++; $display("FAIL k3_exact_const: got %0d/%0b expected 225/0", o, h); end
        start_op(1, 3, 3, 1'b0, 1'b1);
        collect(1, "k1_3x3", o, h);
        checks++;
        if (o !== 32'd7 || h !== 1'b1) begin failures++; $display("FAIL k1_3x3_const: got %0d/%0b expected 7/1", o, h); end
        start_op(1, 12, 12, 1'b0, 1'b1);
        collect(1, "k1_12x12", o, h);
        checks++;
        if (o !== 32'd144 || h !== 1'b0) begin failures++; $display("FAIL k1_12x12_const: got %0d/%0b expected 144/0", o, h); end
    endtask

    task automatic test_backpressure();
        int          cyc;
        bit          ok;
        logic [31:0] o;
        logic        h;
        if2.out_ready = 1'b0;
        start_op(2, 200, 100, 1'b0, 1'b1);
        wait_out(2, cyc, ok);
        check_result(2, "bp", cyc, ok, 1'b0, o, h);
        for (int n = 0; n < 5; n++) begin
            @(posedge clk);
            #1;
            checks++;
            if (get_ov(2) !== 1'b1 || get_ir(2) !== 1'b0 || get_out(2) !== o || get_hit(2) !== h) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d: got ov=%0b ir=%0b out=%0d expected ov=1 ir=0 out=%0d", n, get_ov(2), get_ir(2), get_out(2), o);
            end
        end
        @(negedge clk);
        if2.out_ready = 1'b1;
        drive_in(2, 1'b1, 1, 1, 1'b0);
        @(posedge clk);
        #1;
        drive_in(2, 1'b0, 1, 1, 1'b0);
        checks++;
        if (get_ov(2) !== 1'b0 || get_ir(2) !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: got ov=%0b ir=%0b expected ov=0 ir=1", get_ov(2), get_ir(2));
        end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] o;
        logic        h;
        start_op(2, 77, 99, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (get_ir(2) !== 1'b1 || get_ov(2) !== 1'b0 || get_out(2) !== 32'd0 || get_hit(2) !== 1'b0) begin
            failures++;
            $display("FAIL midrun_reset: got ir=%0b ov=%0b out=%0d hit=%0b expected 1/0/0/0", get_ir(2), get_ov(2), get_out(2), get_hit(2));
        end
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (get_ov(2) !== 1'b0) begin failures++; $display("FAIL midrun_aborted: got ov=%0b expected 0", get_ov(2)); end
        start_op(2, 255, 255, 1'b1, 1'b1);
        collect(2, "after_reset", o, h);
        checks++;
        if (o !== 32'd65025 || h !== 1'b0) begin failures++; $display("FAIL after_reset_const: got %0d/%0b expected 65025/0", o, h); end
    endtask

    task automatic test_ignore_inputs();
        int          cyc;
        bit          ok;
        logic [31:0] o;
        logic        h;
        start_op(2, 37, 201, 1'b0, 1'b1);
        cyc = 0;
        ok  = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            checks++;
            if (get_ir(2) !== 1'b0) begin failures++; $display("FAIL ign_in_ready: got %0b expected 0", get_ir(2)); end
            drive_in(2, 1'b1, int'($urandom_range(255)), int'($urandom_range(255)), 1'($urandom_range(1)));
            @(posedge clk);
            #1;
            cyc++;
            if (get_ov(2) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        drive_in(2, 1'b0, 0, 0, 1'b0);
        check_result(2, "ignore", cyc, ok, 1'b1, o, h);
    endtask

    task automatic test_back_to_back();
        logic [31:0] o;
        logic        h;
        int          av;
        int          bv;
        int          sel;
        bit          m;
        for (int n = 0; n < 12; n++) begin
            sel = (n % 3 == 0) ? 0 : 2;
            if (n == 1) begin av = 255; bv = 255; m = 1'b0; end
            else if (n == 2) begin av = 0; bv = 0; m = 1'b0; end
            else begin
                av = int'($urandom_range((1 << cfg_w(sel)) - 1));
                bv = int'($urandom_range((1 << cfg_w(sel)) - 1));
                m  = 1'($urandom_range(1));
            end
            start_op(sel, av, bv, m, 1'b1);
            collect(sel, "b2b", o, h);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        drive_in(0, 1'b0, 0, 0, 1'b0);
        drive_in(1, 1'b0, 0, 0, 1'b0);
        drive_in(2, 1'b0, 0, 0, 1'b0);
        if0.out_ready = 1'b1;
        if1.out_ready = 1'b1;
        if2.out_ready = 1'b1;
        test_reset();
        test_small_vectors();
        test_backpressure();
        test_reset_mid_run();
        test_ignore_inputs();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/approx_mul_iter.md
APPROX_MUL_ITER -- requirements
Module: approx_mul_iter

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; even values 2..16 only (D = WIDTH/2 = number of 2-bit digits).
REQ-002 Parameter APPROX_K, default 2, digit-pair threshold: pair (i,j) uses the approximate cell when i+j < APPROX_K; 0 = fully exact; 2D-1 = fully approximate.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 in_valid  input  1  operands and mode present.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 a  input  WIDTH  unsigned multiplicand.
REQ-008 b  input  WIDTH  unsigned multiplier.
REQ-009 mode_exact  input  1  1 = force every pair exact for this operation.
REQ-010 out_valid  output  1  product available.
REQ-011 out_ready  input  1  consumer takes product.
REQ-012 out  output  2*WIDTH  unsigned product.
REQ-013 approx_hit  output  1  1 = at least one approximated pair had both digits = 3 (out differs from exact).

Function
REQ-014 States: IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 Accept on an edge with in_valid && in_ready: latch a, b, mode_exact; clear accumulator and approx_hit; pair counter = 0; go RUN.
REQ-016 In RUN, each edge processes one pair (i,j), i = a-digit, j = b-digit, counter order j outer, i inner: acc += cell(a[2i+1:2i], b[2j+1:2j]) << 2(i+j).
REQ-017 Cell: 4-bit product of two 2-bit digits; approximate variant equals exact except 3x3 = 7 (exact 9).
REQ-018 Pair is approximate iff mode_exact latched 0 and i+j < APPROX_K.
REQ-019 approx_hit sets when an approximate pair has both digits 3; sticky until next accept.
REQ-020 After the D*D-th RUN edge go DONE; out_valid rises exactly D*D cycles after the accept edge (WIDTH=8: 16 cycles).
REQ-021 Accumulator 2*WIDTH bits, no overflow possible (approximate result <= exact result).
REQ-022 DONE holds out and approx_hit stable for any length of out_ready = 0.
REQ-023 Edge with out_valid && out_ready: go IDLE; no new accept that same edge (in_ready was 0).
REQ-024 in_valid while RUN/DONE: ignored, operands not sampled, no queueing.
REQ-025 Operand inputs changing during RUN: no effect (latched copies used).

Reset
REQ-026 reset = 1 at an edge: state IDLE, in_ready = 1, out_valid = 0, out = 0, approx_hit = 0, counter = 0, from any state including mid-RUN (operation aborted, no output produced).
REQ-027 reset takes priority over accept and output handshake on the same edge.

Structure
REQ-028 Package approx_mul_pkg: state encoding constants (IDLE/RUN/DONE), digit width 2, cell product width 4.
REQ-029 Sub-module approx_mul2_cell: combinational, inputs x[1:0], y[1:0], approx; output p[3:0]; instantiated once, time-shared across pairs.
REQ-030 No multipliers wider than 2x2 in the design; accumulation by shift and add only.

Verification
REQ-031 WIDTH=4, APPROX_K=3, a=15, b=15, mode_exact=0 -> out=175, approx_hit=1, out_valid 4 cycles after accept.
REQ-032 Same operands, mode_exact=1 -> out=225, approx_hit=0.
REQ-033 WIDTH=4, APPROX_K=1: a=3, b=3 -> out=7, approx_hit=1; a=12, b=12 -> out=144, approx_hit=0.
REQ-034 WIDTH=8, APPROX_K=2, a=200, b=100, out_ready held 0 for 5 cycles after out_valid -> out stable, in_ready=0 throughout, then handshake -> IDLE next cycle.
REQ-035 reset asserted at RUN cycle 3 of a WIDTH=8 op -> next cycle IDLE, out=0, out_valid=0; subsequent a=255, b=255, mode_exact=1 -> out=65025.
REQ-036 in_valid pulsed with new operands during RUN -> ignored; result matches original operands.
